instr_mem_responder: RTL and testbench

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_array.sv | 40 ++++
 rtl/instr_mem_responder.sv | 141 ++++++++++++++
 tb/tb_instr_mem_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
//==============================================================================
// Package : imem_pkg
// Brief   : Shared types and constants for the instruction memory responder.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package imem_pkg;

    localparam int c_DEPTH_DEFAULT = 256;
    localparam int c_INSTR_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
//==============================================================================
// Module : imem_array
// Brief  : Instruction storage, one synchronous write port and one registered
//          read port (read-during-write returns the old word).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_array #(
    parameter int DEPTH  = 256,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] r_rdata_q;

    // Contents are deliberately not reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata_q <= r_mem_q[i_raddr];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule

`default_nettype wire

// File: rtl/instr_mem_responder.sv
//==============================================================================
// Module : instr_mem_responder
// Brief  : Fetch responder: IDLE/BUSY/RESP handshake around imem_array with a
//          completed-response counter. Optional macro IMEM_BOUNDS_CHECK_EN
//          flags addresses >= DEPTH instead of wrapping them.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_mem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic                     flush,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [c_INSTR_W-1:0]     resp_data,
    output logic                     resp_err,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [c_INSTR_W-1:0]     wr_data,
    output logic [CNT_W-1:0]         resp_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    state_e               r_state_q;
    state_e               w_state_d;
    logic [c_ADDR_W-1:0]  r_addr_q;
    logic [c_ADDR_W-1:0]  w_addr_d;
    logic [CNT_W-1:0]     r_count_q;
    logic [CNT_W-1:0]     w_count_d;
    logic                 w_accept;
    logic                 w_handshake;
    logic [c_INSTR_W-1:0] w_rdata;

    // A draining RESP can take the next request on the same edge it completes.
    assign req_ready   = !reset && ((r_state_q == ST_IDLE) ||
                                    ((r_state_q == ST_RESP) && resp_ready));
    assign w_accept    = req_valid && req_ready && !flush;
    assign w_handshake = (r_state_q == ST_RESP) && resp_ready && !flush;
    assign resp_valid  = (r_state_q == ST_RESP);
    assign resp_count  = r_count_q;

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_count_d = r_count_q + {{(CNT_W-1){1'b0}}, w_handshake};
        if (w_accept) begin
            w_addr_d = req_addr[c_ADDR_W-1:0];
        end
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_d = w_accept ? ST_BUSY : ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            w_state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_addr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_count_q <= w_count_d;
        end
    end

`ifdef IMEM_BOUNDS_CHECK_EN
    logic r_oob_q;
    logic w_oob_d;

    // The range flag is taken from the full address at acceptance and held
    // with the transaction until the next acceptance.
    always_comb begin
        w_oob_d = r_oob_q;
        if (w_accept) begin
            w_oob_d = (req_addr >= 32'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_oob_q <= 1'b0;
        end else begin
            r_oob_q <= w_oob_d;
        end
    end

    assign resp_err  = resp_valid && r_oob_q;
    assign resp_data = (resp_valid && !r_oob_q) ? w_rdata : '0;
`else
    logic w_unused_addr_hi;

    assign w_unused_addr_hi = ^req_addr[31:c_ADDR_W];
    assign resp_err         = 1'b0;
    assign resp_data        = resp_valid ? w_rdata : '0;
`endif

    imem_array #(
        .DEPTH  (DEPTH),
        .WIDTH  (c_INSTR_W),
        .ADDR_W (c_ADDR_W)
    ) u_imem_array (
        .clk     (clk),
        .i_we    (wr_en && !reset),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_re    (r_state_q == ST_BUSY),
        .i_raddr (r_addr_q),
        .o_rdata (w_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
//==============================================================================
// Module : tb_instr_mem_responder
// Brief  : Self-checking bench for instr_mem_responder against a
//          transaction-level reference model. Honours IMEM_BOUNDS_CHECK_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_mem_responder;

    localparam int DEPTH = 256;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic [31:0]      req_addr = '0;
    logic             flush = 1'b0;
    logic             resp_ready = 1'b0;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_addr = '0;
    logic [31:0]      wr_data = '0;
    logic             req_ready;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic             resp_err;
    logic [CNT_W-1:0] resp_count;

    instr_mem_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .resp_count (resp_count)
    );

    always #5 clk = ~clk;

    // Reference model: a word store plus "request in flight" / "response held".
    logic [31:0]      m_mem [DEPTH];
    bit               m_cap;
    bit               m_has;
    logic [31:0]      m_cap_addr;
    logic [31:0]      m_data;
    logic             m_err;
    logic [CNT_W-1:0] m_count;
    int               n_checks = 0;
    int               n_fail = 0;

    function automatic logic m_ready();
        return !reset && !m_cap && (!m_has || resp_ready);
    endfunction

    function automatic void exp_word(input logic [31:0] a, output logic [31:0] d, output logic e);
`ifdef IMEM_BOUNDS_CHECK_EN
        if (a >= 32'(DEPTH)) begin
            d = '0;
            e = 1'b1;
        end else begin
            d = m_mem[a % DEPTH];
            e = 1'b0;
        end
`else
        d = m_mem[a % DEPTH];
        e = 1'b0;
`endif
    endfunction

    task automatic set_in(input logic v, input logic [31:0] a, input logic rr, input logic fl);
        req_valid  = v;
        req_addr   = a;
        resp_ready = rr;
        flush      = fl;
        wr_en      = 1'b0;
    endtask

    // Advance the model across one rising edge, then step the DUT to the next falling edge.
    task automatic tick();
        logic        rdy;
        logic [31:0] d;
        logic        e;
        rdy = m_ready();
        if (reset) begin
            m_has   = 0;
            m_cap   = 0;
            m_count = '0;
        end else begin
            if (flush) begin
                m_has = 0;
                m_cap = 0;
            end else begin
                if (m_cap) begin
                    exp_word(m_cap_addr, d, e);
                    m_data = d;
                    m_err  = e;
                    m_has  = 1;
                    m_cap  = 0;
                end else if (m_has && resp_ready) begin
                    m_has   = 0;
                    m_count = m_count + 1'b1;
                end
                if (req_valid && rdy) begin
                    m_cap      = 1;
                    m_cap_addr = req_addr;
                end
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        set_in(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic preload();
        reset = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_addr = 8'(i);
            wr_data = (i == 5) ? 32'hDEADBEEF : $urandom;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b1, 32'd5, 1'b1, 1'b0);
        wr_en   = 1'b1;
        wr_addr = 8'd9;
        wr_data = 32'h0BAD0BAD;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        tick();
        wr_en = 1'b0;
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
        n_checks++; if (resp_count !== '0) begin n_fail++; $display("FAIL reset_resp_count: got %0d want 0", resp_count); end
        reset = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_single();
        set_in(1'b1, 32'd5, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_busy_valid: got %b want 0", resp_valid); end
        tick();
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency_valid: got %b want 1", resp_valid); end
        n_checks++; if (resp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", resp_data); end
        tick();
        n_checks++; if (resp_count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", resp_count); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_done_valid: got %b want 0", resp_valid); end
    endtask

    task automatic test_backpressure();
        set_in(1'b1, 32'd3, 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'd6, 1'b0, 1'b0);
            #1;
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
            n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, resp_valid); end
            n_checks++; if (resp_data !== m_mem[3]) begin n_fail++; $display("FAIL bp_data_stable[%0d]: got %h want %h", i, resp_data, m_mem[3]); end
            tick();
        end
        set_in(1'b1, 32'd6, 1'b1, 1'b0);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_b2b_busy: got %b want 0", resp_valid); end
        tick();
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_b2b_valid: got %b want 1", resp_valid); end
        n_checks++; if (resp_data !== m_mem[6]) begin n_fail++; $display("FAIL bp_b2b_data: got %h want %h", resp_data, m_mem[6]); end
        tick();
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] c0;
        c0 = m_count;
        set_in(1'b1, 32'd8, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_busy_valid: got %b want 0", resp_valid); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_busy_idle: got %b want 1", req_ready); end
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_busy_late: got %b want 0", resp_valid); end
        n_checks++; if (resp_count !== c0) begin n_fail++; $display("FAIL flush_busy_count: got %0d want %0d", resp_count, c0); end
        set_in(1'b1, 32'd8, 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'd9, 1'b1, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_count !== c0) begin n_fail++; $display("FAIL flush_resp_count: got %0d want %0d", resp_count, c0); end
        tick();
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b want 0", resp_valid); end
    endtask

    task automatic test_bounds();
        logic [31:0] d;
        logic        e;
`ifdef IMEM_BOUNDS_CHECK_EN
        d = 32'h0;
        e = 1'b1;
`else
        d = m_mem[44];
        e = 1'b0;
`endif
        set_in(1'b1, 32'd300, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bounds_valid: got %b want 1", resp_valid); end
        n_checks++; if (resp_data !== d) begin n_fail++; $display("FAIL bounds_data: got %h want %h", resp_data, d); end
        n_checks++; if (resp_err !== e) begin n_fail++; $display("FAIL bounds_err: got %b want %b", resp_err, e); end
        tick();
    endtask

    task automatic test_read_during_write();
        logic [31:0] old_w;
        logic [31:0] new_w;
        old_w = m_mem[7];
        new_w = ~old_w ^ 32'h1234_5678;
        set_in(1'b1, 32'd7, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        wr_en   = 1'b1;
        wr_addr = 8'd7;
        wr_data = new_w;
        tick();
        wr_en = 1'b0;
        n_checks++; if (resp_data !== old_w) begin n_fail++; $display("FAIL rdw_old: got %h want %h", resp_data, old_w); end
        tick();
        set_in(1'b1, 32'd7, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_checks++; if (resp_data !== new_w) begin n_fail++; $display("FAIL rdw_new: got %h want %h", resp_data, new_w); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            set_in($urandom_range(0, 1) == 1, 32'($urandom_range(0, 511)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 8'($urandom_range(16, 255));
            wr_data = $urandom;
            #1;
            n_checks++; if (req_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_req_ready[%0d]: got %b want %b", i, req_ready, m_ready()); end
            n_checks++; if (resp_valid !== m_has) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, resp_valid, m_has); end
            n_checks++; if (resp_count !== m_count) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, resp_count, m_count); end
            if (m_has) begin
                n_checks++; if (resp_data !== m_data) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, resp_data, m_data); end
                n_checks++; if (resp_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, resp_err, m_err); end
            end
            tick();
        end
        reset = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] c0;
        c0 = m_count;
        for (int i = 0; i < 36; i++) begin
            set_in(1'b1, 32'(i % 16), 1'b1, 1'b0);
            #1;
            n_checks++; if (resp_valid !== ((i >= 2) && (i % 2 == 0))) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b", i, resp_valid); end
            tick();
        end
        n_checks++; if (resp_count !== CNT_W'(c0 + 17)) begin n_fail++; $display("FAIL b2b_count_wrap: got %0d want %0d", resp_count, CNT_W'(c0 + 17)); end
        drain();
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 32'd5, 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", resp_data); end
        n_checks++; if (resp_count !== '0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", resp_count); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_req_ready: got %b want 0", req_ready); end
        reset = 1'b0;
        set_in(1'b1, 32'd5, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_checks++; if (resp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rmid_preload5: got %h want deadbeef", resp_data); end
        tick();
        set_in(1'b1, 32'd9, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_checks++; if (resp_data !== m_mem[9]) begin n_fail++; $display("FAIL rmid_wr_ignored: got %h want %h", resp_data, m_mem[9]); end
        tick();
    endtask

    initial begin
        m_cap   = 0;
        m_has   = 0;
        m_count = '0;
        m_data  = '0;
        m_err   = 1'b0;
        @(negedge clk);
        preload();
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_bounds();
        test_read_during_write();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
